// File: rtl/sar_conv_sequencer.sv
// rtl/sar_conv_sequencer.sv - round-robin SAR conversion scheduler with settle, averaging and eoc timeout
module sar_conv_sequencer #(
  parameter int DATA_W        = 8,
  parameter int NUM_CH        = 4,
  parameter int CH_W          = 2,
  parameter int AVG_LOG2      = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNVST_CYCLES  = 2,
  parameter int TIMEOUT       = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic              adc_cnvst,
  input  logic              adc_eoc,
  input  logic [DATA_W-1:0] adc_sar,
  output logic [CH_W-1:0]   mux_sel,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [CH_W-1:0]   res_ch,
  output logic              res_err,
  output logic              busy
);

  localparam int NUM_SAMPLES = 1 << AVG_LOG2;
  localparam int ACC_W       = DATA_W + AVG_LOG2;
  localparam int SC_W        = AVG_LOG2 + 1;
  localparam int CNT_MAX_A   = (SETTLE_CYCLES > CNVST_CYCLES) ? SETTLE_CYCLES : CNVST_CYCLES;
  localparam int CNT_MAX     = (CNT_MAX_A > TIMEOUT) ? CNT_MAX_A : TIMEOUT;
  localparam int CNT_W       = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_SETTLE,
    S_START,
    S_WAIT_EOC,
    S_ACCUM,
    S_OUTPUT
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [SC_W-1:0]   sample_cnt;
  logic [ACC_W-1:0]  acc;
  logic              eoc_q;
  logic [CH_W-1:0]   last_ch;

  logic              settle_done;
  logic              cnvst_done;
  logic              timeout_hit;
  logic              eoc_rise;
  logic              last_sample;
  logic              sel_found;
  logic [CH_W-1:0]   sel_ch;
  logic [CH_W-1:0]   cand;

  assign settle_done = (cnt == CNT_W'(SETTLE_CYCLES - 1));
  assign cnvst_done  = (cnt == CNT_W'(CNVST_CYCLES - 1));
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
  assign eoc_rise    = adc_eoc & ~eoc_q;
  assign last_sample = (sample_cnt == SC_W'(NUM_SAMPLES - 1));

  // Round-robin pick: first enabled channel after the last one served, wrapping around
  always_comb begin
    sel_found = 1'b0;
    sel_ch    = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = CH_W'((int'(last_ch) + i) % NUM_CH);
      if (!sel_found && ch_mask[cand]) begin
        sel_found = 1'b1;
        sel_ch    = cand;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and state-decoded outputs
  always_comb begin
    state_nxt = state;
    adc_cnvst = 1'b0;
    res_valid = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE:     if (enable && (|ch_mask)) state_nxt = S_SELECT;
      S_SELECT:   state_nxt = sel_found ? S_SETTLE : S_IDLE;
      S_SETTLE:   if (settle_done) state_nxt = S_START;
      S_START: begin
        adc_cnvst = 1'b1;
        if (cnvst_done) state_nxt = S_WAIT_EOC;
      end
      S_WAIT_EOC: begin
        if (eoc_rise)         state_nxt = S_ACCUM;
        else if (timeout_hit) state_nxt = S_OUTPUT;
      end
      S_ACCUM:    state_nxt = last_sample ? S_OUTPUT : S_START;
      S_OUTPUT: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = enable ? S_SELECT : S_IDLE;
      end
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Datapath: counters, accumulator, mux select and held result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      sample_cnt <= '0;
      acc        <= '0;
      eoc_q      <= 1'b0;
      last_ch    <= CH_W'(NUM_CH - 1);
      mux_sel    <= '0;
      res_data   <= '0;
      res_ch     <= '0;
      res_err    <= 1'b0;
    end else begin
      eoc_q <= adc_eoc;
      case (state)
        S_SELECT: begin
          if (sel_found) mux_sel <= sel_ch;
          acc        <= '0;
          sample_cnt <= '0;
          cnt        <= '0;
        end
        S_SETTLE: cnt <= settle_done ? '0 : cnt + CNT_W'(1);
        S_START:  cnt <= cnvst_done ? '0 : cnt + CNT_W'(1);
        S_WAIT_EOC: begin
          if (eoc_rise) begin
            acc <= acc + ACC_W'(adc_sar);
          end else if (timeout_hit) begin
            res_err  <= 1'b1;
            res_data <= '0;
            res_ch   <= mux_sel;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_ACCUM: begin
          cnt        <= '0;
          sample_cnt <= sample_cnt + SC_W'(1);
          if (last_sample) begin
            res_data <= acc[ACC_W-1:AVG_LOG2];
            res_ch   <= mux_sel;
            res_err  <= 1'b0;
          end
        end
        S_OUTPUT: if (res_ready) last_ch <= res_ch;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_conv_sequencer.sv
// tb/tb_sar_conv_sequencer.sv - directed self-checking bench for sar_conv_sequencer
module tb_sar_conv_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [3:0] ch_mask;
  logic       adc_cnvst;
  logic       adc_eoc;
  logic [7:0] adc_sar;
  logic [1:0] mux_sel;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [1:0] res_ch;
  logic       res_err;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] tbl [4][4];
  int         samp_idx [4];
  bit         eoc_en [4];
  int         eoc_delay = 3;

  sar_conv_sequencer dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ch_mask(ch_mask),
    .adc_cnvst(adc_cnvst), .adc_eoc(adc_eoc), .adc_sar(adc_sar),
    .mux_sel(mux_sel), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_ch(res_ch), .res_err(res_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // SAR model: eoc rises eoc_delay negedges after cnvst falls, drops when cnvst rises
  initial begin
    int  dly;
    bit  prev;
    dly = 0;
    prev = 1'b0;
    adc_eoc = 1'b0;
    adc_sar = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        adc_eoc = 1'b0;
        dly = 0;
        prev = 1'b0;
      end else begin
        if (adc_cnvst && !prev) begin
          adc_eoc = 1'b0;
        end else if (!adc_cnvst && prev) begin
          dly = eoc_delay;
        end else if (dly > 0) begin
          dly--;
          if (dly == 0 && eoc_en[mux_sel]) begin
            adc_sar = tbl[mux_sel][samp_idx[mux_sel]];
            samp_idx[mux_sel] = (samp_idx[mux_sel] + 1) % 4;
            adc_eoc = 1'b1;
          end
        end
        prev = adc_cnvst;
      end
    end
  end

  task automatic init_model();
    for (int c = 0; c < 4; c++) begin
      samp_idx[c] = 0;
      eoc_en[c] = 1'b1;
      for (int k = 0; k < 4; k++) tbl[c][k] = 8'h00;
    end
    tbl[0][0] = 8'hA0; tbl[0][1] = 8'hA1; tbl[0][2] = 8'hA2; tbl[0][3] = 8'hA3;
    for (int k = 0; k < 4; k++) tbl[1][k] = 8'hFF;
    for (int k = 0; k < 4; k++) tbl[2][k] = 8'h10;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    res_ready = 1'b0;
    ch_mask = 4'b0000;
    init_model();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_valid(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (res_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    bit cnv_seen, busy_seen;
    do_reset();
    vectors++; if (adc_cnvst !== 1'b0) begin miscompares++; $display("FAIL rst_cnvst: got %b expected 0", adc_cnvst); end
    vectors++; if (mux_sel !== 2'd0) begin miscompares++; $display("FAIL rst_mux_sel: got %0d expected 0", mux_sel); end
    vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b expected 0", res_valid); end
    vectors++; if (res_data !== 8'h00) begin miscompares++; $display("FAIL rst_data: got %h expected 00", res_data); end
    vectors++; if (res_ch !== 2'd0) begin miscompares++; $display("FAIL rst_ch: got %0d expected 0", res_ch); end
    vectors++; if (res_err !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %b expected 0", res_err); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b expected 0", busy); end
    cnv_seen = 1'b0;
    busy_seen = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (adc_cnvst !== 1'b0) cnv_seen = 1'b1;
      if (busy !== 1'b0) busy_seen = 1'b1;
    end
    vectors++; if (cnv_seen) begin miscompares++; $display("FAIL idle_cnvst: got toggle expected steady 0"); end
    vectors++; if (busy_seen) begin miscompares++; $display("FAIL idle_busy: got 1 expected 0"); end
  endtask

  task automatic test_basic_scan();
    int c, w;
    bit got;
    do_reset();
    ch_mask = 4'b0101;
    res_ready = 1'b1;
    enable = 1'b1;
    c = 0;
    while (busy !== 1'b1 && c < 50) begin @(negedge clk); c++; end
    c = 0;
    while (adc_cnvst !== 1'b1 && c < 50) begin @(negedge clk); c++; end
    vectors++; if (c != 5) begin miscompares++; $display("FAIL select_to_cnvst: got %0d expected 5", c); end
    w = 0;
    while (adc_cnvst === 1'b1 && w < 50) begin w++; @(negedge clk); end
    vectors++; if (w != 2) begin miscompares++; $display("FAIL cnvst_width: got %0d expected 2", w); end
    wait_valid(200, got);
    vectors++; if (!got) begin miscompares++; $display("FAIL scan_res0_timeout: got no valid expected valid"); end
    vectors++; if (res_ch !== 2'd0 || res_data !== 8'hA1 || res_err !== 1'b0) begin
      miscompares++; $display("FAIL scan_res0: got ch%0d %h err%b expected ch0 a1 err0", res_ch, res_data, res_err); end
    @(negedge clk);
    vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL scan_valid_drop: got %b expected 0", res_valid); end
    wait_valid(200, got);
    vectors++; if (!got || res_ch !== 2'd2 || res_data !== 8'h10 || res_err !== 1'b0) begin
      miscompares++; $display("FAIL scan_res1: got v%b ch%0d %h err%b expected ch2 10 err0", got, res_ch, res_data, res_err); end
    @(negedge clk);
    wait_valid(200, got);
    vectors++; if (!got || res_ch !== 2'd0 || res_data !== 8'hA1) begin
      miscompares++; $display("FAIL scan_res2: got v%b ch%0d %h expected ch0 a1", got, res_ch, res_data); end
    enable = 1'b0;
  endtask

  task automatic test_full_scale();
    int c;
    bit got;
    do_reset();
    ch_mask = 4'b0010;
    res_ready = 1'b1;
    enable = 1'b1;
    wait_valid(200, got);
    vectors++; if (!got || res_ch !== 2'd1 || res_data !== 8'hFF || res_err !== 1'b0) begin
      miscompares++; $display("FAIL fs_res0: got v%b ch%0d %h err%b expected ch1 ff err0", got, res_ch, res_data, res_err); end
    @(negedge clk);
    c = 0;
    while (adc_cnvst !== 1'b1 && c < 50) begin @(negedge clk); c++; end
    vectors++; if (c != 5) begin miscompares++; $display("FAIL fs_resettle: got %0d expected 5", c); end
    vectors++; if (mux_sel !== 2'd1) begin miscompares++; $display("FAIL fs_mux_sel: got %0d expected 1", mux_sel); end
    wait_valid(200, got);
    vectors++; if (!got || res_ch !== 2'd1 || res_data !== 8'hFF) begin
      miscompares++; $display("FAIL fs_res1: got v%b ch%0d %h expected ch1 ff", got, res_ch, res_data); end
    enable = 1'b0;
  endtask

  task automatic test_timeout();
    int c;
    bit got;
    do_reset();
    eoc_en[3] = 1'b0;
    ch_mask = 4'b1001;
    res_ready = 1'b1;
    enable = 1'b1;
    wait_valid(200, got);
    vectors++; if (!got || res_ch !== 2'd0 || res_data !== 8'hA1 || res_err !== 1'b0) begin
      miscompares++; $display("FAIL to_res0: got v%b ch%0d %h err%b expected ch0 a1 err0", got, res_ch, res_data, res_err); end
    @(negedge clk);
    c = 0;
    while (adc_cnvst !== 1'b1 && c < 50) begin @(negedge clk); c++; end
    c = 0;
    while (adc_cnvst === 1'b1 && c < 50) begin @(negedge clk); c++; end
    c = 0;
    while (res_valid !== 1'b1 && c < 200) begin @(negedge clk); c++; end
    vectors++; if (c != 64) begin miscompares++; $display("FAIL to_latency: got %0d expected 64", c); end
    vectors++; if (res_ch !== 2'd3 || res_data !== 8'h00 || res_err !== 1'b1) begin
      miscompares++; $display("FAIL to_res3: got ch%0d %h err%b expected ch3 00 err1", res_ch, res_data, res_err); end
    @(negedge clk);
    wait_valid(200, got);
    vectors++; if (!got || res_ch !== 2'd0 || res_data !== 8'hA1 || res_err !== 1'b0) begin
      miscompares++; $display("FAIL to_next: got v%b ch%0d %h err%b expected ch0 a1 err0", got, res_ch, res_data, res_err); end
    enable = 1'b0;
  endtask

  task automatic test_backpressure();
    bit got, unstable, cnv_seen, extra;
    logic [7:0] d0;
    logic [1:0] c0;
    do_reset();
    ch_mask = 4'b0001;
    res_ready = 1'b0;
    enable = 1'b1;
    wait_valid(200, got);
    vectors++; if (!got || res_data !== 8'hA1 || res_ch !== 2'd0) begin
      miscompares++; $display("FAIL bp_res: got v%b ch%0d %h expected ch0 a1", got, res_ch, res_data); end
    d0 = res_data;
    c0 = res_ch;
    unstable = 1'b0;
    cnv_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_data !== d0 || res_ch !== c0) unstable = 1'b1;
      if (adc_cnvst !== 1'b0) cnv_seen = 1'b1;
    end
    vectors++; if (unstable) begin miscompares++; $display("FAIL bp_hold: got changing result expected stable ch%0d %h", c0, d0); end
    vectors++; if (cnv_seen) begin miscompares++; $display("FAIL bp_cnvst: got 1 expected 0 while stalled"); end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL bp_valid_drop: got %b expected 0", res_valid); end
    extra = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (res_valid !== 1'b0) extra = 1'b1;
    end
    vectors++; if (extra) begin miscompares++; $display("FAIL bp_single: got extra valid expected none"); end
    enable = 1'b0;
  endtask

  task automatic test_enable_drop();
    int c, rises;
    bit got, prev, busy_seen;
    do_reset();
    ch_mask = 4'b0101;
    res_ready = 1'b1;
    enable = 1'b1;
    rises = 0;
    prev = 1'b0;
    c = 0;
    while (rises < 2 && c < 200) begin
      @(negedge clk);
      c++;
      if (adc_cnvst && !prev) rises++;
      prev = adc_cnvst;
    end
    enable = 1'b0;
    wait_valid(200, got);
    vectors++; if (!got || res_ch !== 2'd0 || res_data !== 8'hA1 || res_err !== 1'b0) begin
      miscompares++; $display("FAIL ed_res: got v%b ch%0d %h err%b expected ch0 a1 err0", got, res_ch, res_data, res_err); end
    busy_seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (busy !== 1'b0 || res_valid !== 1'b0) busy_seen = 1'b1;
    end
    vectors++; if (busy_seen) begin miscompares++; $display("FAIL ed_idle: got busy/valid expected idle"); end
  endtask

  task automatic test_reset_mid();
    int c;
    bit got, valid_seen;
    do_reset();
    ch_mask = 4'b0100;
    res_ready = 1'b1;
    enable = 1'b1;
    c = 0;
    while (adc_cnvst !== 1'b1 && c < 50) begin @(negedge clk); c++; end
    c = 0;
    while (adc_cnvst === 1'b1 && c < 50) begin @(negedge clk); c++; end
    @(negedge clk);
    vectors++; if (mux_sel !== 2'd2 || busy !== 1'b1) begin
      miscompares++; $display("FAIL rm_pre: got mux%0d busy%b expected mux2 busy1", mux_sel, busy); end
    rst_n = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0 || mux_sel !== 2'd0 || adc_cnvst !== 1'b0 || res_valid !== 1'b0) begin
      miscompares++; $display("FAIL rm_async: got busy%b mux%0d cnvst%b valid%b expected all 0", busy, mux_sel, adc_cnvst, res_valid); end
    enable = 1'b0;
    init_model();
    @(negedge clk);
    rst_n = 1'b1;
    valid_seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (res_valid !== 1'b0 || busy !== 1'b0) valid_seen = 1'b1;
    end
    vectors++; if (valid_seen) begin miscompares++; $display("FAIL rm_no_result: got activity expected none"); end
    enable = 1'b1;
    wait_valid(200, got);
    vectors++; if (!got || res_ch !== 2'd2 || res_data !== 8'h10 || res_err !== 1'b0) begin
      miscompares++; $display("FAIL rm_restart: got v%b ch%0d %h err%b expected ch2 10 err0", got, res_ch, res_data, res_err); end
    enable = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    res_ready = 1'b0;
    ch_mask = 4'b0000;
    init_model();
    test_reset();
    test_basic_scan();
    test_full_scale();
    test_timeout();
    test_backpressure();
    test_enable_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sar_conv_sequencer.md
Name: sar_conv_sequencer

Overview:
Conversion scheduler that sits in front of sar_logic and owns its cnvst/eoc/sar interface.
- Scans the enabled channels of an external analog input mux in round-robin order.
- Waits a settle time after each mux change, then runs 2^AVG_LOG2 back-to-back conversions per channel and averages them.
- Presents one averaged result per channel on a valid/ready output port, with a timeout error if eoc never arrives.

Parameters:
DATA_W, 8, SAR result width (matches sar bus)
NUM_CH, 4, number of mux channels
CH_W, 2, mux select width, clog2(NUM_CH)
AVG_LOG2, 2, log2 of samples averaged per channel (0 = no averaging)
SETTLE_CYCLES, 4, clocks between mux change and first cnvst
CNVST_CYCLES, 2, clocks cnvst is held high per conversion
TIMEOUT, 64, max clocks waiting for eoc rising edge before abort

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous, active-low reset
enable  input  1  level; high = scan continuously
ch_mask  input  NUM_CH  channel enable mask, sampled at channel selection
adc_cnvst  output  1  to sar_logic cnvst
adc_eoc  input  1  from sar_logic eoc
adc_sar  input  DATA_W  from sar_logic sar
mux_sel  output  CH_W  analog mux select
res_valid  output  1  result available
res_ready  input  1  downstream accepts result
res_data  output  DATA_W  averaged result
res_ch  output  CH_W  channel of res_data
res_err  output  1  result aborted by eoc timeout
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n low): state IDLE; all of the following are 0: adc_cnvst, mux_sel, res_valid, res_data, res_ch, res_err, busy, accumulator, sample count, eoc edge register. Last-served channel pointer = NUM_CH-1, so the first scan starts at channel 0.
- Reset asserted mid-operation aborts immediately; the partial accumulation is discarded.
- IDLE: leave when enable=1 and ch_mask!=0; go to SELECT.
- SELECT (1 cycle):
  - Pick the first set ch_mask bit, searching from last pointer+1 with wrap.
  - Drive mux_sel with it, clear accumulator and sample count, go to SETTLE.
  - If the mask reads 0 at this point, go to IDLE.
- SETTLE: count SETTLE_CYCLES clocks, then go to START.
- START: adc_cnvst=1 for exactly CNVST_CYCLES clocks, then deassert and go to WAIT_EOC. Clear the timeout counter on entry.
- WAIT_EOC:
  - Act only on a rising edge of adc_eoc (registered previous value), detected after cnvst falls; a level already high on entry is ignored.
  - On an edge, capture adc_sar into the accumulator the same cycle; go to ACCUM.
  - Timeout counter increments each cycle. When it reaches TIMEOUT: res_err=1, res_data=0, skip the remaining samples, go to OUTPUT.
- ACCUM (1 cycle):
  - Accumulator is DATA_W+AVG_LOG2 bits wide; it cannot overflow.
  - sample count+1. If count < 2^AVG_LOG2, go to START (no re-settle). Otherwise res_data = acc >> AVG_LOG2 (truncate) and go to OUTPUT.
- OUTPUT:
  - res_valid=1; res_data, res_ch and res_err are held stable until the cycle where res_valid & res_ready.
  - After the transfer, res_valid=0 the next cycle, pointer = res_ch. Go to SELECT if enable=1, else IDLE.
  - Backpressure stalls the scan; no result is ever dropped.
- enable deasserted mid-channel: the current channel completes and its result is delivered, then IDLE.
- ch_mask changes take effect only at SELECT.
- Single-channel mask: the same channel is repeated, with SETTLE on every pass.
- Latency per channel (no stall, eoc edge after E clocks) = 1 + SETTLE_CYCLES + 2^AVG_LOG2*(CNVST_CYCLES+E+1) clocks to res_valid.

Test Plan:
- rst_n=0 then release, enable=0 -> all outputs 0, busy=0, adc_cnvst never toggles for 50 clocks.
- enable=1, ch_mask=4'b0101, eoc model delivering 8'hA0,A1,A2,A3 on ch0 and 8'h10 x4 on ch2, res_ready=1 -> results (ch0, 8'hA1, err=0), then (ch2, 8'h10); then ch0 again. adc_cnvst pulses are exactly 2 clocks; first cnvst rises 5 clocks after SELECT.
- Samples 8'hFF x4 on ch1, mask=4'b0010 -> res_data=8'hFF (no overflow). Every pass shows mux_sel=1 plus a 4-clock settle.
- eoc held low on ch3 -> res_err=1, res_data=0, res_ch=3, 64 clocks after cnvst falls. Scan continues with the next channel.
- res_ready=0 for 20 clocks with res_valid=1 -> res_data/res_ch stable, adc_cnvst stays 0. Ready pulse -> single transfer; valid drops next cycle.
- enable dropped during the 2nd sample of ch0 -> ch0 result still delivered, then IDLE, busy=0. rst_n pulsed low mid-WAIT_EOC -> immediate return to reset values, no result emitted.
